// File: rtl/snake_score_counter.sv
// snake_score_counter: packed-BCD score with queued points that roll in one per clock, plus session high score
module snake_score_counter #(
    parameter int SCORE_WIDTH     = 16,
    parameter int POINTS_PER_FOOD = 1,
    parameter int PENDING_WIDTH   = 6
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic                   i_Food_Eaten,
    input  logic                   i_Clear,
    output logic [SCORE_WIDTH-1:0] o_Score,
    output logic [SCORE_WIDTH-1:0] o_High_Score,
    output logic                   o_Busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] SAT  = 2'd2;
    localparam logic [SCORE_WIDTH-1:0] MAX_SCORE = {(SCORE_WIDTH/4){4'h9}};

    logic [1:0]               state;
    logic [PENDING_WIDTH-1:0] pending;
    logic [PENDING_WIDTH-1:0] pending_next;
    logic [PENDING_WIDTH:0]   pending_sum;
    logic [SCORE_WIDTH-1:0]   score_inc;
    logic                     carry;

    // pending points: add food, drain one while rolling, clamp at all-ones instead of wrapping
    always_comb begin
        pending_sum  = {1'b0, pending}
                     + (i_Food_Eaten ? (PENDING_WIDTH+1)'(POINTS_PER_FOOD) : (PENDING_WIDTH+1)'(0))
                     - ((state == ADD) ? (PENDING_WIDTH+1)'(1) : (PENDING_WIDTH+1)'(0));
        pending_next = pending_sum[PENDING_WIDTH] ? '1 : pending_sum[PENDING_WIDTH-1:0];
    end

    // decimal +1 on the packed digits, rippling the carry through every digit that was 9
    always_comb begin
        score_inc = o_Score;
        carry     = 1'b1;
        for (int i = 0; i < SCORE_WIDTH/4; i++) begin
            if (carry) begin
                if (o_Score[4*i +: 4] == 4'd9) begin
                    score_inc[4*i +: 4] = 4'd0;
                end else begin
                    score_inc[4*i +: 4] = o_Score[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    assign o_Busy = (state == ADD);

    // score, pending and state; high score tracks the pre-edge score so a clear never loses the last point
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            o_Score      <= '0;
            o_High_Score <= '0;
            pending      <= '0;
            state        <= IDLE;
        end else begin
            if (o_Score > o_High_Score)
                o_High_Score <= o_Score;
            if (i_Clear) begin
                o_Score <= '0;
                pending <= '0;
                state   <= IDLE;
            end else if (state == ADD) begin
                if (o_Score == MAX_SCORE) begin
                    pending <= '0;
                    state   <= SAT;
                end else begin
                    o_Score <= score_inc;
                    pending <= pending_next;
                    if (pending_next == '0)
                        state <= IDLE;
                end
            end else if (state == IDLE) begin
                pending <= pending_next;
                if (pending != '0)
                    state <= ADD;
            end
        end
    end
endmodule

// File: tb/tb_snake_score_counter.sv
// tb_snake_score_counter: randomized and directed stimulus against an integer score model via a scoreboard queue
module tb_snake_score_counter;
    localparam int P = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        food = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] score;
    logic [15:0] high;
    logic        busy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] s;
        logic [15:0] h;
        logic        b;
    } exp_t;
    exp_t q[$];

    int m_score = 0;
    int m_high = 0;
    int m_pend = 0;
    bit m_roll = 0;
    bit m_sat = 0;

    snake_score_counter #(.SCORE_WIDTH(16), .POINTS_PER_FOOD(P), .PENDING_WIDTH(6)) dut (
        .i_Clk(clk),
        .i_Reset(rst),
        .i_Food_Eaten(food),
        .i_Clear(clr),
        .o_Score(score),
        .o_High_Score(high),
        .o_Busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int clamp(input int v);
        return (v > 63) ? 63 : v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // reference model: decimal score, integer points owed, rolling/saturated flags
    always @(posedge clk) begin
        if (rst) begin
            m_score = 0; m_high = 0; m_pend = 0; m_roll = 0; m_sat = 0;
        end else begin
            if (m_score > m_high) m_high = m_score;
            if (clr) begin
                m_score = 0; m_pend = 0; m_roll = 0; m_sat = 0;
            end else if (m_sat) begin
            end else if (m_roll) begin
                if (m_score == 9999) begin
                    m_sat = 1; m_roll = 0; m_pend = 0;
                end else begin
                    m_score++;
                    m_pend = clamp(m_pend + (food ? P : 0) - 1);
                    if (m_pend == 0) m_roll = 0;
                end
            end else begin
                if (m_pend != 0) m_roll = 1;
                m_pend = clamp(m_pend + (food ? P : 0));
            end
        end
        q.push_back('{to_bcd(m_score), to_bcd(m_high), m_roll});
    end

    // monitor: compare the registered outputs shortly after every edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard at %0t: no expected entry", $time);
        end else begin
            e = q.pop_front();
            check("score", score, e.s);
            check("high", high, e.h);
            check("busy", {15'd0, busy}, {15'd0, e.b});
        end
    end

    task automatic cyc(input bit f, input bit c);
        @(negedge clk);
        food = f;
        clr = c;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0);
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            cyc(1, 0);
            idle(2);
        end
    endtask

    initial begin
        idle(3);
        rst = 1'b0;
        cyc(1, 0); idle(8);
        cyc(0, 1); pulses(66); idle(6);
        cyc(1, 0); idle(6);
        pulses(267); idle(6);
        cyc(1, 0); cyc(1, 0); cyc(1, 0); idle(14);
        repeat (300) cyc($urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);
        idle(30);
        cyc(0, 1); cyc(1, 0); cyc(1, 0); idle(3);
        #2 rst = 1'b1;
        #1;
        check("reset_score", score, 16'h0000);
        check("reset_high", high, 16'h0000);
        check("reset_busy", {15'd0, busy}, 16'h0000);
        cyc(0, 0);
        rst = 1'b0;
        idle(10);
        pulses(34); idle(6);
        cyc(0, 1); pulses(84); idle(6);
        cyc(1, 1); idle(6);
        pulses(40); idle(6);
        cyc(0, 1); pulses(3332); idle(6);
        cyc(1, 0); cyc(1, 0); idle(14);
        repeat (5) cyc(1, 0);
        idle(6);
        cyc(0, 1); pulses(3); idle(8);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/snake_score_counter.md
Name: snake_score_counter

Overview:
- Produces the 4-digit packed-BCD score that drives the seven-segment scoreboard (digit 3 in [15:12] down to digit 0 in [3:0]).
- Counts food-eaten events from the game controller and queues the points they earn.
- Drains the queued points into the displayed score at one BCD increment per clock, so the score visibly rolls up.
- Holds a session high score and clears the current score on a new-game request.

Parameters:
- SCORE_WIDTH, 16, packed BCD score width; fixed at 16 (four digits); other values unsupported.
- POINTS_PER_FOOD, 1, points queued per food event; legal range 1..15.
- PENDING_WIDTH, 6, width of the pending-points accumulator.

Ports:
- i_Clk  input  1  system clock; all state on rising edge.
- i_Reset  input  1  asynchronous, active-high reset.
- i_Food_Eaten  input  1  single-cycle pulse per food eaten; every high cycle counts as one event.
- i_Clear  input  1  synchronous new-game request; clears current score and pending points.
- o_Score  output  16  current score, packed BCD 0000..9999.
- o_High_Score  output  16  highest score since reset, packed BCD.
- o_Busy  output  1  high while in ADD state (points still rolling in).

Behaviour:
- Reset: asynchronous, active-high.
  - o_Score=16'h0000, o_High_Score=16'h0000, o_Busy=0, pending=0, state=IDLE; applies immediately on assertion.
  - Mid-roll reset discards pending points.
- Pending accumulator, updated each edge:
  - pending_next = pending + (i_Food_Eaten ? POINTS_PER_FOOD : 0) - (state==ADD ? 1 : 0).
  - Saturates at 2^PENDING_WIDTH-1; excess points are dropped, never wrap.
  - Simultaneous add and drain in one cycle nets correctly.
- FSM states: IDLE, ADD, SAT.
  - IDLE: pending==0 -> stay. pending!=0 -> ADD; no score change on that edge.
  - ADD: each edge o_Score <= BCD(o_Score+1).
    - Go to IDLE when pending_next==0.
    - If o_Score==16'h9999 at the edge, do not increment; go to SAT and force pending to 0.
  - SAT: o_Score held at 9999. Food events are ignored; pending stays 0. o_Busy=0. Exit only via i_Clear or reset.
- BCD increment:
  - Digit 0 +1. Any digit reaching 9 and carried becomes 0 and carries to the next digit.
  - Example: 0199 -> 0200; 0999 -> 1000.
  - Digits never hold A..F.
- Latency:
  - A pulse sampled at edge k is in pending after edge k.
  - The FSM enters ADD at edge k+1.
  - The first +1 appears on o_Score after edge k+2; one further +1 per edge after that.
  - N points from idle: o_Busy high for N cycles; the score is final after edge k+1+N.
- i_Clear:
  - Next edge: o_Score=0000, pending=0, state=IDLE.
  - Has priority over a same-cycle i_Food_Eaten, which is dropped.
  - o_High_Score is not cleared.
- High score:
  - Each edge, if o_Score > o_High_Score then o_High_Score <= o_Score. Plain unsigned compare is valid for packed BCD.
  - This lags o_Score by one edge.
  - On the edge where i_Clear is sampled, the update still uses the pre-clear o_Score, so the final increment is never lost.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset asserted mid-ADD (score 0042, pending 5) -> all outputs 0 immediately (before the next edge); after release, no further increments.
- Pulse i_Food_Eaten one cycle at edge k, POINTS_PER_FOOD=3 -> o_Score 0001/0002/0003 after edges k+2/k+3/k+4; o_Busy high for exactly 3 cycles; o_High_Score 0003 one edge later.
- Score preloaded to 0198 by 198 events; queue 3 points -> sequence 0199, 0200, 0201; no hex digits appear. Also check 0999 -> 1000.
- Pulses on 3 consecutive cycles (POINTS_PER_FOOD=1) while in ADD -> pending nets correctly; final o_Score = start+3.
- Score at 9997 with 5 pending -> 9998, 9999, then SAT. Pending is cleared, o_Busy drops, and further pulses leave the score at 9999.
- Score 0250, high 0100: assert i_Clear together with i_Food_Eaten -> next edge o_Score=0000, o_High_Score=0250, no points queued. The next game reaching 0120 leaves high at 0250.
